// File: rtl/wb_retire_queue.sv
// ---------------------------------------------------------------------------
// wb_retire_queue
//
// Writeback retire queue. Buffers up to DEPTH completed MEM-stage results and
// retires the oldest one per cycle to the GPR write port. When another writer
// owns the RF port (rf_busy), the head is held. ID can look up queued,
// not-yet-written results through a youngest-first forwarding port.
//
// Optional feature macro: WB_DEBUG_TRACE_EN adds the debug_wb_* trace ports.
//
// Ports
//   clk, resetn            clock (posedge) / asynchronous active-low reset
//   in_valid, in_ready     MEM result handshake; in_ready depends only on
//                          registered occupancy
//   in_pc/in_we/in_waddr/in_wdata   result payload
//   rf_busy                RF port taken this cycle; head is held
//   rf_we/rf_waddr/rf_wdata         GPR write port (head entry)
//   fwd_raddr -> fwd_hit, fwd_data  ID-stage forwarding lookup
//   count                  occupancy
//   debug_wb_pc/_rf_wen/_rf_wnum/_rf_wdata  retire trace (macro only)
// ---------------------------------------------------------------------------
module wb_retire_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            in_pc,
  input  logic                       in_we,
  input  logic [ADDR_W-1:0]          in_waddr,
  input  logic [DATA_W-1:0]          in_wdata,
  input  logic                       rf_busy,
  output logic                       rf_we,
  output logic [ADDR_W-1:0]          rf_waddr,
  output logic [DATA_W-1:0]          rf_wdata,
  input  logic [ADDR_W-1:0]          fwd_raddr,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data,
  output logic [$clog2(DEPTH):0]     count
`ifdef WB_DEBUG_TRACE_EN
  ,
  output logic [PC_W-1:0]            debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [ADDR_W-1:0]          debug_wb_rf_wnum,
  output logic [DATA_W-1:0]          debug_wb_rf_wdata
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DEPTH-1:0]  r_vld;

  // Payload storage carries no reset: every consumer is gated by r_vld/r_count.
  logic [PC_W-1:0]   r_pc    [DEPTH];
  logic [DEPTH-1:0]  r_we;
  logic [ADDR_W-1:0] r_waddr [DEPTH];
  logic [DATA_W-1:0] r_wdata [DEPTH];

  logic              w_nonempty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;

  assign w_nonempty = (r_count != '0);
  // A full queue refuses input even if the head retires this cycle, which
  // keeps rf_busy out of the in_ready path.
  assign w_full     = (r_count == CNT_W'(DEPTH));
  assign w_push     = in_valid & ~w_full;
  assign w_pop      = w_nonempty & ~rf_busy;

  // Control state: pointers, occupancy and entry valid bits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr        <= r_rd_ptr + 1'b1;
        r_vld[r_rd_ptr] <= 1'b0;
      end
      // Push and pop never target the same slot: push at count==0 implies no
      // pop, and pop at count==DEPTH implies no push.
      if (w_push) begin
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        r_vld[r_wr_ptr] <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload write.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_wr_ptr]    <= in_pc;
      r_we[r_wr_ptr]    <= in_we;
      r_waddr[r_wr_ptr] <= in_waddr;
      r_wdata[r_wr_ptr] <= in_wdata;
    end
  end

  // Walk from oldest (rd_ptr) to youngest; a later match overwrites an earlier
  // one, so the youngest matching entry wins regardless of pointer wrap.
  always_comb begin
    logic [PTR_W-1:0] idx;
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = r_rd_ptr + PTR_W'(i);
      if (r_vld[idx] && r_we[idx] && (r_waddr[idx] != '0) &&
          (r_waddr[idx] == fwd_raddr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_wdata[idx];
      end
    end
  end

  assign in_ready = ~w_full;
  assign count    = r_count;
  assign fwd_hit  = w_fwd_hit;
  assign fwd_data = w_fwd_data;

  // Register 0 and we=0 entries still retire, just without a write strobe.
  assign rf_we    = w_pop & r_we[r_rd_ptr] & (r_waddr[r_rd_ptr] != '0);
  assign rf_waddr = w_nonempty ? r_waddr[r_rd_ptr] : '0;
  assign rf_wdata = w_nonempty ? r_wdata[r_rd_ptr] : '0;

`ifdef WB_DEBUG_TRACE_EN
  assign debug_wb_pc       = w_pop ? r_pc[r_rd_ptr] : '0;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_retire_queue.sv
// ---------------------------------------------------------------------------
// tb_wb_retire_queue
//
// Self-checking bench for wb_retire_queue. A queue-based reference model
// tracks the buffered results; every cycle all outputs are compared against
// values derived from that model, plus directed scenario checks.
// ---------------------------------------------------------------------------
module tb_wb_retire_queue;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int PC_W   = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              resetn;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic              in_we;
  logic [ADDR_W-1:0] in_waddr;
  logic [DATA_W-1:0] in_wdata;
  logic              rf_busy;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] fwd_raddr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  count;
`ifdef WB_DEBUG_TRACE_EN
  logic [PC_W-1:0]   debug_wb_pc;
  logic [3:0]        debug_wb_rf_wen;
  logic [ADDR_W-1:0] debug_wb_rf_wnum;
  logic [DATA_W-1:0] debug_wb_rf_wdata;
`endif

  wb_retire_queue #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_we     (in_we),
    .in_waddr  (in_waddr),
    .in_wdata  (in_wdata),
    .rf_busy   (rf_busy),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .fwd_raddr (fwd_raddr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .count     (count)
`ifdef WB_DEBUG_TRACE_EN
    ,
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } ent_t;

  ent_t mq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected outputs straight from the queue contents and current inputs.
  task automatic check_model();
    logic              e_we;
    logic [ADDR_W-1:0] e_wa;
    logic [DATA_W-1:0] e_wd;
    logic              e_hit;
    logic [DATA_W-1:0] e_fd;
    logic              e_ret;
    e_we = 1'b0; e_wa = '0; e_wd = '0; e_hit = 1'b0; e_fd = '0;
    e_ret = (mq.size() != 0) && !rf_busy;
    if (mq.size() != 0) begin
      e_wa = mq[0].waddr;
      e_wd = mq[0].wdata;
      e_we = mq[0].we && (mq[0].waddr != 0) && !rf_busy;
    end
    for (int k = mq.size() - 1; k >= 0; k--) begin
      if (!e_hit && mq[k].we && mq[k].waddr != 0 && mq[k].waddr == fwd_raddr) begin
        e_hit = 1'b1;
        e_fd  = mq[k].wdata;
      end
    end
    check("count",    64'(count),    64'(mq.size()));
    check("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
    check("rf_we",    64'(rf_we),    64'(e_we));
    check("rf_waddr", 64'(rf_waddr), 64'(e_wa));
    check("rf_wdata", 64'(rf_wdata), 64'(e_wd));
    check("fwd_hit",  64'(fwd_hit),  64'(e_hit));
    check("fwd_data", 64'(fwd_data), 64'(e_fd));
`ifdef WB_DEBUG_TRACE_EN
    check("dbg_pc",   64'(debug_wb_pc),       e_ret ? 64'(mq[0].pc) : 64'd0);
    check("dbg_wen",  64'(debug_wb_rf_wen),   64'({4{e_we}}));
    check("dbg_wnum", 64'(debug_wb_rf_wnum),  64'(e_wa));
    check("dbg_wdat", 64'(debug_wb_rf_wdata), 64'(e_wd));
`endif
  endtask

  // Called just after a posedge: apply inputs, check at negedge, advance the
  // model at the next posedge.
  task automatic step(input logic v, input logic [PC_W-1:0] pc, input logic we,
                      input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                      input logic busy, input logic [ADDR_W-1:0] ra);
    logic acc, ret;
    ent_t e;
    in_valid = v; in_pc = pc; in_we = we; in_waddr = wa; in_wdata = wd;
    rf_busy = busy; fwd_raddr = ra;
    @(negedge clk);
    check_model();
    @(posedge clk);
    acc = v && (mq.size() != DEPTH);
    ret = (mq.size() != 0) && !busy;
    if (ret) void'(mq.pop_front());
    if (acc) begin
      e.pc = pc; e.we = we; e.waddr = wa; e.wdata = wd;
      mq.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input logic busy);
    step(1'b0, '0, 1'b0, '0, '0, busy, '0);
  endtask

  task automatic hold_inputs(input logic busy, input logic [ADDR_W-1:0] ra);
    in_valid = 1'b0; rf_busy = busy; fwd_raddr = ra;
    #1;
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_pc = '0; in_we = 1'b0; in_waddr = '0;
    in_wdata = '0; rf_busy = 1'b0; fwd_raddr = '0;
    repeat (2) @(negedge clk);
    check("rst_count",    64'(count),    64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_rf_we",    64'(rf_we),    64'd0);
    check("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    check("rst_fwd_hit",  64'(fwd_hit),  64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // T1 single pass
    step(1'b1, 32'hBFC00000, 1'b1, 5'd8, 32'h1234, 1'b0, 5'd0);
    hold_inputs(1'b0, 5'd8);
    check("t1_rf_we",    64'(rf_we),    64'd1);
    check("t1_rf_waddr", 64'(rf_waddr), 64'd8);
    check("t1_rf_wdata", 64'(rf_wdata), 64'h1234);
    check("t1_fwd_hit",  64'(fwd_hit),  64'd1);
    idle(1'b0);
    check("t1_count0",   64'(count),    64'd0);

    // T2 fill, ignored push, in-order drain
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'h1000 + 32'(i), 1'b1, 5'(i + 1), 32'h100 + 32'(i), 1'b1, 5'(i));
    hold_inputs(1'b1, 5'd0);
    check("t2_count4", 64'(count),    64'd4);
    check("t2_ready0", 64'(in_ready), 64'd0);
    step(1'b1, 32'h2000, 1'b1, 5'd9, 32'hDEAD, 1'b1, 5'd9);
    check("t2_5th_ign", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      hold_inputs(1'b0, 5'd0);
      check("t2_ret_addr", 64'(rf_waddr), 64'(i + 1));
      check("t2_ret_data", 64'(rf_wdata), 64'h100 + 64'(i));
      idle(1'b0);
    end
    check("t2_empty", 64'(count), 64'd0);

    // T3 youngest-first forwarding
    step(1'b1, 32'h3000, 1'b1, 5'd5, 32'hAA, 1'b1, 5'd5);
    step(1'b1, 32'h3004, 1'b1, 5'd5, 32'hBB, 1'b1, 5'd5);
    hold_inputs(1'b1, 5'd5);
    check("t3_hit",   64'(fwd_hit),  64'd1);
    check("t3_data",  64'(fwd_data), 64'hBB);
    hold_inputs(1'b1, 5'd0);
    check("t3_r0_hit",  64'(fwd_hit),  64'd0);
    check("t3_r0_data", 64'(fwd_data), 64'd0);
    idle(1'b0); idle(1'b0);

    // T4 $zero and no-write entries
    step(1'b1, 32'h4000, 1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0);
    step(1'b1, 32'h4004, 1'b0, 5'd3, 32'h77,   1'b1, 5'd3);
    hold_inputs(1'b0, 5'd3);
    check("t4_we_a",  64'(rf_we),   64'd0);
    check("t4_cnt2",  64'(count),   64'd2);
    check("t4_nohit", 64'(fwd_hit), 64'd0);
    idle(1'b0);
    hold_inputs(1'b0, 5'd0);
    check("t4_we_b", 64'(rf_we), 64'd0);
    check("t4_cnt1", 64'(count), 64'd1);
    idle(1'b0);
    check("t4_cnt0", 64'(count), 64'd0);

    // T5 steady push+retire at count 3 across pointer wrap
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h5000 + 32'(i), 1'b1, 5'(10 + i), 32'h500 + 32'(i), 1'b1, 5'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h5100 + 32'(i), 1'b1, 5'(10 + (i % 5)), 32'h510 + 32'(i), 1'b0, 5'(10 + (i % 5)));
      check("t5_cnt3", 64'(count), 64'd3);
    end
    repeat (3) idle(1'b0);

    // T6 async reset mid-operation
    step(1'b1, 32'h6000, 1'b1, 5'd6, 32'h60, 1'b1, 5'd6);
    step(1'b1, 32'h6004, 1'b1, 5'd7, 32'h61, 1'b1, 5'd6);
    hold_inputs(1'b0, 5'd6);
    #1 resetn = 1'b0;
    #1;
    check("t6_count",    64'(count),    64'd0);
    check("t6_rf_we",    64'(rf_we),    64'd0);
    check("t6_in_ready", 64'(in_ready), 64'd1);
    check("t6_fwd_hit",  64'(fwd_hit),  64'd0);
    mq.delete();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    step(1'b1, 32'h6100, 1'b1, 5'd9, 32'h99, 1'b0, 5'd9);
    hold_inputs(1'b0, 5'd9);
    check("t6_post_we",   64'(rf_we),    64'd1);
    check("t6_post_addr", 64'(rf_waddr), 64'd9);
    idle(1'b0);

    // Randomized traffic with varying backpressure density
    for (int i = 0; i < 800; i++) begin
      logic busy;
      busy = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 7) != 0),
           5'($urandom_range(0, 7)), $urandom(), busy, 5'($urandom_range(0, 7)));
    end
    repeat (DEPTH + 1) idle(1'b0);
    check("final_empty", 64'(count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
